// File: rtl/bcd_tick_counter.sv
// Prescaled N-digit packed-BCD up/down counter with clear, clamped parallel load,
// wrap-or-saturate terminal handling, a step tick and a terminal-event pulse.
module bcd_tick_counter #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 2500000,
  parameter int PRESCALE_BITS = 22,
  parameter bit WRAP          = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    term_pulse,
  output logic                    at_limit
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [PRESCALE_BITS-1:0] PS_LAST = PRESCALE_BITS'(PRESCALE - 1);

  logic [PRESCALE_BITS-1:0] psc;
  logic                     step;
  logic                     all_nines;
  logic                     all_zeros;
  logic                     cy;
  logic [W-1:0]             stepped;
  logic [W-1:0]             clamped;
  logic [W-1:0]             digits_next;

  assign step = enable && (psc == PS_LAST);

  always_comb begin
    all_nines = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (digits[4*i +: 4] != 4'd0) all_zeros = 1'b0;
    end
  end

  assign at_limit = up_down ? all_nines : all_zeros;

  // Carry/borrow ripples through every digit in one edge; from the terminal
  // value this naturally lands on the wrapped value.
  always_comb begin
    stepped = digits;
    cy      = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (up_down) begin
          if (digits[4*i +: 4] == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = digits[4*i +: 4] + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (digits[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = digits[4*i +: 4] - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamped = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'd9;
    end
  end

  assign digits_next = (at_limit && !WRAP) ? digits : stepped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc        <= '0;
      digits     <= '0;
      tick       <= 1'b0;
      term_pulse <= 1'b0;
    end else if (clear) begin
      psc        <= '0;
      digits     <= '0;
      tick       <= 1'b0;
      term_pulse <= 1'b0;
    end else if (load) begin
      psc        <= '0;
      digits     <= clamped;
      tick       <= 1'b0;
      term_pulse <= 1'b0;
    end else begin
      tick       <= step;
      term_pulse <= step && at_limit;
      if (enable) psc <= step ? '0 : psc + PRESCALE_BITS'(1);
      if (step) digits <= digits_next;
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench: a decimal-integer model of a wrapping and a saturating
// 2-digit, prescale-3 counter predicts each edge; results are compared after it.
module tb_bcd_tick_counter;

  localparam int N = 2;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst, enable, up_down, clear, load;
  logic [4*N-1:0] load_val;
  logic [4*N-1:0] digits_w, digits_s;
  logic tick_w, tick_s, term_w, term_s, al_w, al_s;

  bcd_tick_counter #(.NUM_DIGITS(N), .PRESCALE(P), .PRESCALE_BITS(2), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val), .digits(digits_w), .tick(tick_w),
    .term_pulse(term_w), .at_limit(al_w));

  bcd_tick_counter #(.NUM_DIGITS(N), .PRESCALE(P), .PRESCALE_BITS(2), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val), .digits(digits_s), .tick(tick_s),
    .term_pulse(term_s), .at_limit(al_s));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dw; logic tw; logic pw; logic aw;
    logic [7:0] ds; logic ts; logic ps; logic as_;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_psc, m_vw, m_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int clamp_dec(input logic [7:0] lv);
    logic [3:0] lo, hi;
    lo = lv[3:0];
    hi = lv[7:4];
    if (lo > 4'd9) lo = 4'd9;
    if (hi > 4'd9) hi = 4'd9;
    return int'(hi) * 10 + int'(lo);
  endfunction

  task automatic model_reset();
    m_psc = 0; m_vw = 0; m_vs = 0;
  endtask

  // One clock edge: predict, push, wait for the edge, pop and compare.
  task automatic step_cycle();
    exp_t e, o;
    logic stp;
    e.tw = 1'b0; e.pw = 1'b0; e.ts = 1'b0; e.ps = 1'b0;
    if (clear) begin
      m_psc = 0; m_vw = 0; m_vs = 0;
    end else if (load) begin
      m_psc = 0; m_vw = clamp_dec(load_val); m_vs = m_vw;
    end else if (enable) begin
      stp = (m_psc == P - 1);
      m_psc = stp ? 0 : m_psc + 1;
      if (stp) begin
        e.tw = 1'b1; e.ts = 1'b1;
        if (up_down) begin
          e.pw = (m_vw == 99); e.ps = (m_vs == 99);
          m_vw = (m_vw + 1) % 100;
          if (m_vs != 99) m_vs = m_vs + 1;
        end else begin
          e.pw = (m_vw == 0); e.ps = (m_vs == 0);
          m_vw = (m_vw + 99) % 100;
          if (m_vs != 0) m_vs = m_vs - 1;
        end
      end
    end
    e.dw  = to_bcd(m_vw);
    e.ds  = to_bcd(m_vs);
    e.aw  = up_down ? (m_vw == 99) : (m_vw == 0);
    e.as_ = up_down ? (m_vs == 99) : (m_vs == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      chk("digits_wrap", 32'(digits_w), 32'(o.dw));
      chk("tick_wrap",   32'(tick_w),   32'(o.tw));
      chk("term_wrap",   32'(term_w),   32'(o.pw));
      chk("limit_wrap",  32'(al_w),     32'(o.aw));
      chk("digits_sat",  32'(digits_s), 32'(o.ds));
      chk("tick_sat",    32'(tick_s),   32'(o.ts));
      chk("term_sat",    32'(term_s),   32'(o.ps));
      chk("limit_sat",   32'(al_s),     32'(o.as_));
    end
  endtask

  task automatic run(input int n, input logic en, input logic ud);
    enable = en; up_down = ud; clear = 1'b0; load = 1'b0;
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic do_load(input logic [7:0] v);
    enable = 1'b0; clear = 1'b0; load = 1'b1; load_val = v;
    step_cycle();
    load = 1'b0;
  endtask

  int found;

  initial begin
    rst = 1'b1; enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digits", 32'(digits_w), 32'h0);
    chk("reset_tick",   32'(tick_w | tick_s), 32'h0);
    chk("reset_term",   32'(term_w | term_s), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run(10, 1'b0, 1'b1);                 // hold with enable low
    run(33, 1'b1, 1'b1);                 // 00 -> 11 through the 09 -> 10 carry
    run(2, 1'b1, 1'b1);                  // prescaler sits on its last count

    enable = 1'b1; clear = 1'b1; load = 1'b1; load_val = 8'hA7;
    step_cycle();                        // clear beats load beats step
    clear = 1'b0;
    step_cycle();                        // clamped load -> 97
    run(3, 1'b1, 1'b1);                  // prescaler restarted from 0

    do_load(8'h99);
    run(4, 1'b1, 1'b1);                  // wrap to 00 / saturate at 99
    do_load(8'h10);
    run(3, 1'b1, 1'b0);                  // borrow -> 09
    do_load(8'h00);
    run(4, 1'b1, 1'b0);                  // wrap to 99 / saturate at 00

    do_load(8'h50);
    run(1, 1'b1, 1'b1);
    run(2, 1'b1, 1'b0);                  // direction sampled at step -> 49

    do_load(8'h45);
    run(2, 1'b1, 1'b1);                  // prescaler = 2
    #2 rst = 1'b1;
    #1;
    chk("async_digits_wrap", 32'(digits_w), 32'h0);
    chk("async_digits_sat",  32'(digits_s), 32'h0);
    chk("async_tick",        32'(tick_w | tick_s), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1; up_down = 1'b1;
    found = 0;
    for (int i = 1; i <= 10 && found == 0; i++) begin
      step_cycle();
      if (tick_w) found = i;
    end
    chk("first_tick_after_reset", 32'(found), 32'd3);

    for (int i = 0; i < 80; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      up_down = $urandom_range(0, 1);
      clear   = ($urandom_range(0, 40) == 0);
      load    = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      step_cycle();
    end
    clear = 1'b0; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
